// File: rtl/vga_buf_pkg.sv
// Shared constants and helpers for the VGA line buffer and the timing block.
//   VGA_*           : default widths/depths for the scan-out path
//   clog2()         : ceiling log2, usable in parameter expressions
//   swap_res_e      : outcome of a swap request at an edge
package vga_buf_pkg;

  localparam int VGA_WORD_WIDTH = 32;
  localparam int VGA_PIX_WIDTH  = 8;
  localparam int VGA_WORDS      = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    SWAP_IDLE     = 2'd0,
    SWAP_DONE     = 2'd1,
    SWAP_UNDERRUN = 2'd2
  } swap_res_e;

endpackage

// File: rtl/vga_sdp_ram.sv
// Simple dual-port RAM, byte-write enables, 1-cycle registered read, no reset.
//   clk         : clock
//   we/waddr    : write strobe / address
//   wbe/wdata   : byte enables (bit i -> wdata[8i+7:8i]) / write data
//   re/raddr    : read strobe / address; rdata holds when re=0
//   rdata       : registered read data
module vga_sdp_ram
  import vga_buf_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW/8-1:0] wbe,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++)
      if (we && wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer between the VGA write port and the scan-out pipe.
//   clk, rst_n          : clock, synchronous active-low reset
//   wr_en/addr/data/be  : word writes into the back bank
//   wr_done             : back bank complete; wr_ready low until next swap
//   wr_drop             : pulse, a write hit a full back bank and was lost
//   rd_en/rd_addr       : pixel read from the front bank
//   rd_data/rd_valid    : registered pixel, valid one cycle after rd_en
//   swap_req/swap_ack   : swap request / pulse when banks actually swapped
//   front_sel           : bank being displayed
//   underrun_cnt        : saturating count of swaps with nothing to show
module vga_line_buffer
  import vga_buf_pkg::*;
#(
  parameter int WORD_WIDTH = VGA_WORD_WIDTH,
  parameter int PIX_WIDTH  = VGA_PIX_WIDTH,
  parameter int WORDS      = VGA_WORDS,
  localparam int PPW = WORD_WIDTH / PIX_WIDTH,
  localparam int WA  = clog2(WORDS),
  localparam int LB  = clog2(PPW),
  localparam int PA  = WA + LB
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [WA-1:0]           wr_addr,
  input  logic [WORD_WIDTH-1:0]   wr_data,
  input  logic [WORD_WIDTH/8-1:0] wr_be,
  input  logic                    wr_done,
  output logic                    wr_ready,
  output logic                    wr_drop,
  input  logic                    rd_en,
  input  logic [PA-1:0]           rd_addr,
  output logic [PIX_WIDTH-1:0]    rd_data,
  output logic                    rd_valid,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    front_sel,
  output logic [7:0]              underrun_cnt
);

  localparam int LBW = (LB > 0) ? LB : 1;

  logic                  back_full;
  logic                  rd_seen;
  logic [LBW-1:0]        rd_lane, lane_q;
  logic [WA-1:0]         rd_word;
  logic [WORD_WIDTH-1:0] ram_q;
  swap_res_e             swap_res;

  assign wr_ready = ~back_full;
  assign rd_word  = rd_addr[PA-1 -: WA];

  generate
    if (LB > 0) begin : g_lane
      assign rd_lane = rd_addr[LBW-1:0];
    end else begin : g_nolane
      assign rd_lane = '0;
    end
  endgenerate

  // Reads and writes always address opposite banks, so no RDW hazard.
  vga_sdp_ram #(
    .DW    (WORD_WIDTH),
    .DEPTH (2 * WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en & ~back_full),
    .waddr ({~front_sel, wr_addr}),
    .wbe   (wr_be),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr ({front_sel, rd_word}),
    .rdata (ram_q)
  );

  // wr_done in the swap cycle counts as a completed back bank.
  always_comb begin
    swap_res = SWAP_IDLE;
    if (swap_req) swap_res = (back_full || wr_done) ? SWAP_DONE : SWAP_UNDERRUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      front_sel    <= 1'b0;
      back_full    <= 1'b0;
      swap_ack     <= 1'b0;
      wr_drop      <= 1'b0;
      underrun_cnt <= 8'd0;
      rd_valid     <= 1'b0;
      rd_seen      <= 1'b0;
      lane_q       <= '0;
    end else begin
      wr_drop  <= wr_en & back_full;
      swap_ack <= (swap_res == SWAP_DONE);
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_seen <= 1'b1;
        lane_q  <= rd_lane;
      end
      if (swap_res == SWAP_DONE) begin
        front_sel <= ~front_sel;
        back_full <= 1'b0;
      end else if (wr_done) begin
        back_full <= 1'b1;
      end
      if (swap_res == SWAP_UNDERRUN && underrun_cnt != 8'hFF)
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  // RAM output is not reset; rd_seen masks it to zero until the first
  // read after reset so rd_data behaves like a reset register.
  assign rd_data = rd_seen ? ram_q[int'(lane_q)*PIX_WIDTH +: PIX_WIDTH] : '0;

endmodule

// File: doc/vga_line_buffer.md
Name: vga_line_buffer

Overview:
Parametrised, single-clock, ping-pong line buffer for the VGA path.
- The CPU/blitter side writes WORD_WIDTH-bit words with byte enables into the back bank.
- The VGA scan-out side reads PIX_WIDTH-bit pixels from the front bank with registered latency.
- Banks swap on a scan-out swap request, and only once the writer has declared the back bank complete.
- Sits between the VGA write port of the core and the VGA timing/colour generator.

Parameters:
- WORD_WIDTH, 32, write word width in bits; multiple of 8 and of PIX_WIDTH.
- PIX_WIDTH, 8, read pixel width in bits; WORD_WIDTH/PIX_WIDTH must be a power of 2.
- WORDS, 64, words per bank; power of 2, at least 2.
- Derived (localparam): PPW = WORD_WIDTH/PIX_WIDTH, WA = log2(WORDS), PA = WA + log2(PPW).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  write strobe into the back bank.
- wr_addr  in  WA  back-bank word address.
- wr_data  in  WORD_WIDTH  write word.
- wr_be  in  WORD_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- wr_done  in  1  pulse: back bank fully written.
- wr_ready  out  1  back bank accepts writes (not yet marked done).
- wr_drop  out  1  1-cycle pulse: a write arrived while wr_ready=0 and was discarded.
- rd_en  in  1  pixel read request.
- rd_addr  in  PA  front-bank pixel index.
- rd_data  out  PIX_WIDTH  registered pixel.
- rd_valid  out  1  rd_data holds the result of the rd_en from the previous cycle.
- swap_req  in  1  pulse from VGA timing, e.g. in hblank.
- swap_ack  out  1  1-cycle pulse: swap performed.
- front_sel  out  1  bank currently being displayed.
- underrun_cnt  out  8  saturating count of swap_req pulses that arrived with no completed back bank.

Behaviour:
- Reset (rst_n=0 at an edge) clears all of the following to 0:
  - front_sel, back_full, rd_data, rd_valid, swap_ack, wr_drop, underrun_cnt.
  - wr_ready=1 after reset.
  - RAM contents are not reset.
- Storage: 2*WORDS words. Physical word address is {bank, word}; the back bank is ~front_sel.
- Write:
  - When wr_en=1 and back_full=0, every byte with its wr_be bit set is written at the edge. Bytes with wr_be=0 keep their value.
  - When wr_en=1 and back_full=1: no write, and wr_drop=1 in the next cycle.
- wr_ready = ~back_full (combinational from the register).
- wr_done sets back_full. A write in the same cycle as wr_done is still accepted.
- Read:
  - Pixel p maps to word p>>log2(PPW) and lane p[log2(PPW)-1:0]. Lane 0 is bits [PIX_WIDTH-1:0].
  - Latency is 1 cycle. Address, lane and bank are sampled at the edge where rd_en=1, and rd_data/rd_valid update at that same edge.
  - With rd_en=0: rd_valid=0 next cycle and rd_data holds its value.
- Swap, evaluated at each edge with swap_req=1:
  - If back_full, or wr_done is in the same cycle: toggle front_sel, clear back_full, swap_ack=1 for one cycle.
  - Otherwise: front_sel is unchanged (the line repeats), underrun_cnt increments and saturates at 255, swap_ack=0.
- A read in the same cycle as a swap uses the old front_sel.
- A write in the same cycle as a swap goes to the old back bank, which becomes the new front bank.
- A wr_done in the same cycle as a swap is consumed by that swap; back_full is 0 afterwards.
- Read-during-write never aliases, because reads and writes always target opposite banks.
- Reset mid-line discards the pending swap state. After reset, bank 0 is front and writes go to bank 1.

Decomposition:
- Package vga_buf_pkg holds a clog2 function and the default width constants shared with the VGA timing block.
- One sub-module, vga_sdp_ram: inferred simple dual-port RAM with byte-write enables and a 1-cycle registered read. It is parametrised in data width and depth and contains no reset.
- vga_line_buffer holds bank control, lane muxing and the counters.

Test Plan:
- Reset, then write word 0x44332211 at addr 0 with be=4'hF, then wr_done and swap_req → swap_ack=1 and front_sel=1; reads of pixels 0..3 return 0x11, 0x22, 0x33, 0x44, each one cycle after rd_en with rd_valid=1.
- Partial write: write 0xAABBCCDD at addr 5 with be=4'b0101 over a previous 0x00000000 → after swap, pixels 20..23 read 0xDD, 0x00, 0xBB, 0x00.
- Underrun: three swap_req pulses with no wr_done → front_sel unchanged, swap_ack=0, underrun_cnt=3. After 300 pulses underrun_cnt=255.
- Back full: after wr_done, a write to addr 1 → wr_drop=1 next cycle, wr_ready=0, and data at addr 1 is unchanged after swap.
- Simultaneous events: wr_done, swap_req and rd_en in the same cycle → swap_ack=1, rd_data comes from the old front bank, and back_full=0 afterwards.
- Mid-operation reset: assert rst_n=0 for one cycle with back_full=1 and rd_en=1 → next cycle front_sel=0, wr_ready=1, rd_valid=0, rd_data=0, underrun_cnt=0.
